// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage between the PC register and decode.
// Issues one memory request at a time over req/ack. Fetched instructions are
// buffered with their addresses in a small FIFO toward decode. A redirect
// flushes the buffer and restarts fetch at a new address.
module ifetch_unit #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // DROP: a redirect arrived while a request was outstanding; the request
   // is kept alive until the memory acks, and its data is thrown away.
   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DROP
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       req_addr_q, req_addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [31:0]       buf_instr_q [DEPTH];
   logic [31:0]       buf_instr_d [DEPTH];
   logic [31:0]       buf_pc_q [DEPTH];
   logic [31:0]       buf_pc_d [DEPTH];
   logic              push;
   logic              pop;

   // Fetch FSM: next state, request capture and push decision.
   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      push       = 1'b0;
      imem_req   = 1'b0;
      case (state_q)
         IDLE: begin
            // Registered count gates issue, so a push can never hit a full buffer.
            if (!redirect && (count_q < DEPTH_C)) begin
               req_addr_d = pc;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               push    = !redirect;
               state_d = IDLE;
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         DROP: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_addr = req_addr_q;

   // Next PC: redirect wins, then sequential advance on a live ack, else hold.
   always_comb begin
      if (redirect) begin
         pc_next = redirect_pc;
      end else if ((state_q == BUSY) && imem_ack) begin
         pc_next = req_addr_q + 32'd4;
      end else begin
         pc_next = pc;
      end
   end

   assign if_valid = (count_q != '0);
   assign pop      = if_valid && if_ready;
   assign if_instr = if_valid ? buf_instr_q[rd_ptr_q] : 32'd0;
   assign if_pc    = if_valid ? buf_pc_q[rd_ptr_q] : 32'd0;

   // FIFO bookkeeping; a redirect flushes everything and drops the same-cycle push.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (!push && pop) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // FIFO storage write: only the slot at the write pointer changes.
   always_comb begin
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      if (push) begin
         buf_instr_d[wr_ptr_q] = imem_rdata;
         buf_pc_d[wr_ptr_q]    = req_addr_q;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         req_addr_q <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_instr_q[i] <= '0;
            buf_pc_q[i]    <= '0;
         end
      end else begin
         state_q     <= state_d;
         req_addr_q  <= req_addr_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenarios with literal expectations followed by a
// randomized run, all checked every cycle against a queue-based model.
module tb_ifetch_unit;

   localparam int DEPTH = 2;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   int checks   = 0;
   int failures = 0;

   // environment state
   logic [31:0] pc_hold   = 32'd0;
   logic [31:0] rst_pc    = 32'd0;
   logic [31:0] last_data = 32'd0;
   int          mem_wait  = 0;
   int          mem_age   = 0;
   bit          mem_rand  = 1'b0;

   // model state
   bit          m_known = 1'b0;
   bit          m_out   = 1'b0;
   bit          m_drop  = 1'b0;
   logic [31:0] m_addr  = 32'd0;
   logic [31:0] q_pc[$];
   logic [31:0] q_ins[$];

   ifetch_unit #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .pc_next    (pc_next),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .if_instr   (if_instr),
      .if_pc      (if_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, emulate memory,
   // then capture pc_next as the PC register would at the rising edge.
   task automatic cycle(input bit rst, input bit rdr, input logic [31:0] rpc, input bit rdy);
      @(negedge clk);
      pc          = rst ? rst_pc : pc_hold;
      reset       = rst;
      redirect    = rdr;
      redirect_pc = rpc;
      if_ready    = rdy;
      if (imem_req === 1'b1) begin
         if (mem_rand && mem_age == 0) mem_wait = $urandom_range(0, 3);
         imem_ack = (mem_age >= mem_wait);
      end else begin
         imem_ack = mem_rand && ($urandom_range(0, 7) == 0);
      end
      imem_rdata = $urandom;
      if (imem_ack) last_data = imem_rdata;
      if (imem_req !== 1'b1 || imem_ack) mem_age = 0;
      else mem_age++;
      #2;
      pc_hold = pc_next;
   endtask

   task automatic do_reset(input logic [31:0] p);
      rst_pc = p;
      cycle(1'b1, 1'b0, 32'd0, 1'b1);
      cycle(1'b1, 1'b0, 32'd0, 1'b1);
      mem_age = 0;
   endtask

   // Compare process: checks DUT outputs against the model every cycle, then advances the model.
   initial begin : compare
      bit          e_valid;
      logic [31:0] e_next;
      int          sz;
      forever begin
         @(negedge clk);
         #1;
         if (m_known) begin
            e_valid = (q_pc.size() > 0);
            if (redirect) e_next = redirect_pc;
            else if (m_out && !m_drop && imem_ack) e_next = m_addr + 32'd4;
            else e_next = pc;
            chk("m_imem_req", 32'(imem_req), 32'(m_out));
            chk("m_imem_addr", imem_addr, m_addr);
            chk("m_if_valid", 32'(if_valid), 32'(e_valid));
            chk("m_if_pc", if_pc, e_valid ? q_pc[0] : 32'd0);
            chk("m_if_instr", if_instr, e_valid ? q_ins[0] : 32'd0);
            chk("m_pc_next", pc_next, e_next);
         end
         if (reset) begin
            m_known = 1'b1;
            m_out   = 1'b0;
            m_drop  = 1'b0;
            m_addr  = 32'd0;
            q_pc.delete();
            q_ins.delete();
         end else if (m_known) begin
            sz = q_pc.size();
            if (sz > 0 && if_ready) begin
               void'(q_pc.pop_front());
               void'(q_ins.pop_front());
            end
            if (redirect) begin
               q_pc.delete();
               q_ins.delete();
            end
            if (m_out) begin
               if (imem_ack) begin
                  if (!m_drop && !redirect) begin
                     q_pc.push_back(m_addr);
                     q_ins.push_back(imem_rdata);
                  end
                  m_out  = 1'b0;
                  m_drop = 1'b0;
               end else if (redirect) begin
                  m_drop = 1'b1;
               end
            end else if (!redirect && sz < DEPTH) begin
               m_addr = pc;
               m_out  = 1'b1;
            end
         end
      end
   end

   initial begin : stimulus
      pc = 32'd0; reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
      if_ready = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;

      // Basic fetch, zero-wait memory
      mem_wait = 0;
      do_reset(32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_pc_next", pc_next, pc);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b0, 32'd0, 1'b1);
         chk("basic_addr", imem_addr, 32'(4 * k));
         chk("basic_pc_next", pc_next, 32'(4 * k + 4));
         cycle(1'b0, 1'b0, 32'd0, 1'b1);
         chk("basic_valid", 32'(if_valid), 32'd1);
         chk("basic_if_pc", if_pc, 32'(4 * k));
         chk("basic_if_instr", if_instr, last_data);
      end

      // Wait states: ack on the 4th request cycle
      mem_wait = 3;
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b0, 32'd0, 1'b1);
         chk("wait_req", 32'(imem_req), 32'd1);
         chk("wait_addr", imem_addr, 32'h0000_000C);
         chk("wait_pc_next", pc_next, 32'h0000_000C);
      end
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("wait_ack_pc_next", pc_next, 32'h0000_0010);
      chk("wait_ack_valid", 32'(if_valid), 32'd0);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("wait_valid", 32'(if_valid), 32'd1);
      chk("wait_if_pc", if_pc, 32'h0000_000C);

      // Backpressure until full, then drain
      mem_wait = 0;
      do_reset(32'd0);
      for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
      chk("bp_req", 32'(imem_req), 32'd0);
      chk("bp_valid", 32'(if_valid), 32'd1);
      chk("bp_if_pc", if_pc, 32'd0);
      chk("bp_pc_next", pc_next, 32'd8);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("bp_drain0", if_pc, 32'd0);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("bp_drain1", if_pc, 32'd4);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("bp_resume_req", 32'(imem_req), 32'd1);
      chk("bp_resume_addr", imem_addr, 32'd8);

      // Redirect with a request outstanding
      mem_wait = 4;
      do_reset(32'd0);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
      chk("rdo_pc_next", pc_next, 32'h0000_0100);
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 1'b0, 32'd0, 1'b1);
         chk("rdo_drop_req", 32'(imem_req), 32'd1);
         chk("rdo_drop_addr", imem_addr, 32'd0);
         chk("rdo_drop_valid", 32'(if_valid), 32'd0);
      end
      mem_wait = 0;
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("rdo_idle_valid", 32'(if_valid), 32'd0);
      chk("rdo_idle_req", 32'(imem_req), 32'd0);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("rdo_new_addr", imem_addr, 32'h0000_0100);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("rdo_first_if_pc", if_pc, 32'h0000_0100);

      // Redirect together with pop and ack
      do_reset(32'd0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
      chk("rpa_valid", 32'(if_valid), 32'd1);
      chk("rpa_if_pc", if_pc, 32'd0);
      chk("rpa_pc_next", pc_next, 32'h0000_0200);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("rpa_after_valid", 32'(if_valid), 32'd0);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("rpa_restart_addr", imem_addr, 32'h0000_0200);

      // Wrap-around, then reset mid-request
      do_reset(32'hFFFF_FFFC);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("wrap_pc_next", pc_next, 32'd0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
      mem_wait = 5;
      rst_pc = 32'd0;
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      chk("rstmid_req_before", 32'(imem_req), 32'd1);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("rstmid_req", 32'(imem_req), 32'd0);
      chk("rstmid_valid", 32'(if_valid), 32'd0);

      // Randomized run
      mem_rand = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] rpc;
         bit          r;
         r      = ($urandom_range(0, 199) == 0);
         rst_pc = $urandom & 32'hFFFF_FFFC;
         rpc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         cycle(r, ($urandom_range(0, 11) == 0), rpc, ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
